interrupt_controller: RTL

Central interrupt arbiter for the GBC core. Collects the five interrupt sources (VBLANK, LCD STAT, TIMER, SERIAL, JOYPAD) into the IF register (0xFF0F). Masks them with IE (0xFFFF) and hands the single highest-priority pending interrupt to the CPU over a request/acknowledge handshake with a fixed vector. Sits on the shared I/O bus beside the timer and LCD blocks; the timer's interrupt output feeds source bit 2.

---
 rtl/interrupt_controller_pkg.sv | 47 ++++
 rtl/interrupt_controller_if.sv | 18 +
 rtl/interrupt_controller_irq_priority_encoder.sv | 24 ++
 rtl/interrupt_controller.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared memory map, vector and state definitions for the interrupt controller.
//   ADDR_IF / ADDR_IE : I/O addresses of the IF and IE registers
//   irq_src_e         : source bit index (also the priority, 0 highest)
//   VEC_BASE_DEF      : dispatch vector of source 0, sources step by 8
//   irq_state_e       : request/acknowledge FSM encoding
package interrupt_controller_pkg;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned IDX_W       = 3;
  localparam int unsigned NUM_SRC_DEF = 5;

  localparam logic [ADDR_W-1:0] ADDR_IF = 16'hFF0F;
  localparam logic [ADDR_W-1:0] ADDR_IE = 16'hFFFF;

  localparam logic [DATA_W-1:0] VEC_BASE_DEF = 8'h40;

  typedef enum logic [IDX_W-1:0] {
    SRC_VBLANK = 3'd0,
    SRC_STAT   = 3'd1,
    SRC_TIMER  = 3'd2,
    SRC_SERIAL = 3'd3,
    SRC_JOYPAD = 3'd4
  } irq_src_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACKD = 2'd2
  } irq_state_e;

  // Decoded view of one I/O bus cycle as seen by this block.
  typedef struct packed {
    logic              wr_if;
    logic              wr_ie;
    logic              rd_if;
    logic              rd_ie;
    logic [DATA_W-1:0] wdata;
  } io_req_t;

  // Dispatch address for source idx: base + 8*idx.
  function automatic logic [DATA_W-1:0] irq_vector(input logic [DATA_W-1:0] base,
                                                   input logic [IDX_W-1:0]  idx);
    return base + DATA_W'({idx, 3'b000});
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// CPU-side interrupt handshake bundle.
//   I_IME        : CPU master interrupt enable
//   I_INT_ACK    : CPU accepts the current request (1-cycle pulse)
//   O_INT_REQ    : request to CPU
//   O_INT_VECTOR : dispatch address, valid while O_INT_REQ
// master = CPU side, slave = interrupt controller side.
interface interrupt_controller_if;
  import interrupt_controller_pkg::*;

  logic              I_IME;
  logic              I_INT_ACK;
  logic              O_INT_REQ;
  logic [DATA_W-1:0] O_INT_VECTOR;

  modport master (output I_IME, output I_INT_ACK, input O_INT_REQ, input O_INT_VECTOR);
  modport slave  (input I_IME, input I_INT_ACK, output O_INT_REQ, output O_INT_VECTOR);

endinterface

// File: rtl/interrupt_controller_irq_priority_encoder.sv
// Combinational priority encoder: lowest set bit of the pending vector wins.
//   pending_i : masked pending interrupts
//   valid_c_o : any bit pending
//   index_c_o : index of the highest-priority (lowest) pending bit
module interrupt_controller_irq_priority_encoder
  import interrupt_controller_pkg::*;
#(
  parameter int unsigned NUM_SRC = NUM_SRC_DEF
) (
  input  logic [NUM_SRC-1:0] pending_i,
  output logic               valid_c_o,
  output logic [IDX_W-1:0]   index_c_o
);

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    valid_c_o = |pending_i;
    index_c_o = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (pending_i[i]) index_c_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// GBC interrupt controller: captures source rising edges into IF, masks with IE
// and dispatches the highest-priority pending interrupt to the CPU.
//   I_CLOCK, I_RESET : clock, asynchronous active-high reset
//   I_ADDR, IO_DATA  : shared I/O bus; IF at 0xFF0F, IE at 0xFFFF
//   I_RE_L, I_WE_L   : active-low read / write strobes
//   I_IRQ_SRC        : raw sources 0 VBLANK, 1 STAT, 2 TIMER, 3 SERIAL, 4 JOYPAD
//   cpu_if           : IME / ack in, request / vector out
//   O_WAKE           : any enabled interrupt pending, ignores IME
//   O_IF_DATA/IE_DATA: debug views of IF (zero-padded) and IE
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int unsigned       NUM_SRC  = NUM_SRC_DEF,
  parameter logic [DATA_W-1:0] VEC_BASE = VEC_BASE_DEF
) (
  input  logic                 I_CLOCK,
  input  logic                 I_RESET,
  input  logic [ADDR_W-1:0]    I_ADDR,
  inout  wire  [DATA_W-1:0]    IO_DATA,
  input  logic                 I_RE_L,
  input  logic                 I_WE_L,
  input  logic [NUM_SRC-1:0]   I_IRQ_SRC,
  interrupt_controller_if.slave cpu_if,
  output logic                 O_WAKE,
  output logic [DATA_W-1:0]    O_IF_DATA,
  output logic [DATA_W-1:0]    O_IE_DATA
);

  irq_state_e          state_q, state_d;
  logic [IDX_W-1:0]    sel_q, sel_d;
  logic                int_req_q, int_req_d;
  logic [DATA_W-1:0]   int_vec_q, int_vec_d;
  logic [NUM_SRC-1:0]  if_q, if_d;
  logic [DATA_W-1:0]   ie_q, ie_d;
  logic [NUM_SRC-1:0]  src_prev_q;

  io_req_t             bus_c;
  logic [DATA_W-1:0]   rd_data_c;
  logic [NUM_SRC-1:0]  rise_c;
  logic [NUM_SRC-1:0]  pending_c;
  logic                pend_valid_c;
  logic [IDX_W-1:0]    pend_idx_c;
  logic                ack_clr_c;

  // Bus decode.
  always_comb begin
    bus_c       = '0;
    bus_c.wdata = IO_DATA;
    bus_c.wr_if = !I_WE_L && (I_ADDR == ADDR_IF);
    bus_c.wr_ie = !I_WE_L && (I_ADDR == ADDR_IE);
    bus_c.rd_if = !I_RE_L && (I_ADDR == ADDR_IF);
    bus_c.rd_ie = !I_RE_L && (I_ADDR == ADDR_IE);
  end

  // Read mux; unimplemented IF bits read as 1.
  always_comb begin
    rd_data_c = '1;
    if (bus_c.rd_ie) begin
      rd_data_c = ie_q;
    end else begin
      rd_data_c[NUM_SRC-1:0] = if_q;
    end
  end

  assign IO_DATA = (bus_c.rd_if || bus_c.rd_ie) ? rd_data_c : {DATA_W{1'bz}};

  assign rise_c    = I_IRQ_SRC & ~src_prev_q;
  assign pending_c = if_q & ie_q[NUM_SRC-1:0];
  assign O_WAKE    = |pending_c;

  interrupt_controller_irq_priority_encoder #(
    .NUM_SRC (NUM_SRC)
  ) u_irq_priority_encoder (
    .pending_i (pending_c),
    .valid_c_o (pend_valid_c),
    .index_c_o (pend_idx_c)
  );

  // IF update: bus write first, then ack-clear, and a fresh source edge wins over both.
  always_comb begin
    if_d = if_q;
    if (bus_c.wr_if) if_d = bus_c.wdata[NUM_SRC-1:0];
    if (ack_clr_c)   if_d[sel_q] = 1'b0;
    if_d = if_d | rise_c;
  end

  always_comb begin
    ie_d = ie_q;
    if (bus_c.wr_ie) ie_d = bus_c.wdata;
  end

  // Interrupt registers and source edge history.
  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      if_q       <= '0;
      ie_q       <= '0;
      src_prev_q <= '0;
    end else begin
      if_q       <= if_d;
      ie_q       <= ie_d;
      src_prev_q <= I_IRQ_SRC;
    end
  end

  // Dispatch FSM next-state and outputs.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    int_req_d = int_req_q;
    int_vec_d = int_vec_q;
    ack_clr_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cpu_if.I_IME && pend_valid_c) begin
          state_d   = ST_REQ;
          sel_d     = pend_idx_c;
          int_req_d = 1'b1;
          int_vec_d = irq_vector(VEC_BASE, pend_idx_c);
        end
      end
      ST_REQ: begin
        if (cpu_if.I_INT_ACK) begin
          ack_clr_c = 1'b1;
          state_d   = ST_ACKD;
          int_req_d = 1'b0;
          int_vec_d = '0;
        end else if (!pending_c[sel_q]) begin
          // Request withdrawn by software clearing IF or IE.
          state_d   = ST_IDLE;
          int_req_d = 1'b0;
          int_vec_d = '0;
        end
      end
      ST_ACKD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        int_req_d = 1'b0;
        int_vec_d = '0;
      end
    endcase
  end

  // Dispatch FSM state register.
  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      int_req_q <= 1'b0;
      int_vec_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      int_req_q <= int_req_d;
      int_vec_q <= int_vec_d;
    end
  end

  assign cpu_if.O_INT_REQ    = int_req_q;
  assign cpu_if.O_INT_VECTOR = int_vec_q;
  assign O_IF_DATA           = DATA_W'(if_q);
  assign O_IE_DATA           = ie_q;

endmodule
